fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_next_pc.sv | 27 ++
 rtl/fetch_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding,
// datapath widths, the sequential PC step and word-alignment helper.
package fetch_pkg;

    localparam int          INSTR_W = 32;
    localparam int          PC_W    = 32;
    localparam logic [31:0] PC_INC  = 32'd4;

    // FSM state encoding, kept as plain constants for legacy tools
    typedef logic [1:0] state_t;
    localparam state_t ST_REQ   = 2'd0;  // request outstanding to imem
    localparam state_t ST_HOLD  = 2'd1;  // instruction held for decode
    localparam state_t ST_DRAIN = 2'd2;  // wait out a request made stale by a redirect

    // Force a byte address onto a word boundary
    function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select: exception vector beats redirect target,
// which beats the sequential pc+4. Redirect targets are word aligned here.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic [PC_W-1:0] pc,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_target,
    input  logic            exc_valid,
    output logic            flush,
    output logic [PC_W-1:0] next_pc
);

    // Priority select of the next PC; the 32-bit add wraps naturally
    always_comb begin
        flush   = exc_valid | redirect_valid;
        next_pc = pc + PC_INC;
        if (exc_valid) begin
            next_pc = align_word(EXC_VECTOR);
        end else if (redirect_valid) begin
            next_pc = align_word(redirect_target);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one word request at a time, hands the
// fetched word to decode, and steers fetch on branches and exceptions.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    input  logic               if_ready,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_target,
    input  logic               exc_valid,
    output logic [PC_W-1:0]    pc_out
);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] fetch_addr;
    logic            flush;
    logic [PC_W-1:0] next_pc;

    fetch_next_pc #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_pc (
        .pc              (pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .exc_valid       (exc_valid),
        .flush           (flush),
        .next_pc         (next_pc)
    );

    // Request is held in REQ and DRAIN; address only moves when no request is live
    always_comb begin
        imem_req  = (state != ST_HOLD);
        imem_addr = fetch_addr;
    end

    assign pc_out = pc;

    // FSM, PC registers and decode output register
    // NOTE: every register here uses <= so all of them sample pre-edge values;
    // the if_* datapath is reset too, since decode may observe it during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_REQ;
            pc         <= RESET_VECTOR;
            fetch_addr <= RESET_VECTOR;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (flush) begin
                        // Request must stay up until acked; only pc moves now
                        pc <= next_pc;
                        if (imem_ack) begin
                            fetch_addr <= next_pc;
                            state      <= ST_REQ;
                        end else begin
                            state      <= ST_DRAIN;
                        end
                    end else if (imem_ack) begin
                        if_instr <= imem_rdata;
                        if_pc    <= fetch_addr;
                        if_valid <= 1'b1;
                        pc       <= next_pc;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (flush) begin
                        // Flush beats a same-cycle decode accept
                        if_valid   <= 1'b0;
                        pc         <= next_pc;
                        fetch_addr <= next_pc;
                        state      <= ST_REQ;
                    end else if (if_valid && if_ready) begin
                        if_valid   <= 1'b0;
                        fetch_addr <= pc;
                        state      <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    // Later redirects overwrite pc; the stale word is dropped on ack
                    if (flush) begin
                        pc <= next_pc;
                    end
                    if (imem_ack) begin
                        fetch_addr <= flush ? next_pc : pc;
                        state      <= ST_REQ;
                    end
                end
                default: begin
                    state <= ST_REQ;
                end
            endcase
        end
    end

endmodule
